// File: rtl/timestamp_reader.sv
// Host-side reader for the trigger-timer capture chain: clocks out CHANNELS*WIDTH
// serial timestamp bits, presents them with a valid/ready handshake, then re-arms the chain.
module timestamp_reader #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 32,
  parameter int HALF_PERIOD  = 4,
  parameter int REARM_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_ready,
  input  logic                        data_in,
  output logic                        data_clk,
  output logic                        target_reset,
  output logic [CHANNELS*WIDTH-1:0]   timestamps,
  output logic                        ts_valid,
  input  logic                        ts_ready,
  output logic                        busy
);

  localparam int N  = CHANNELS * WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int PW = $clog2(HALF_PERIOD);
  localparam int RW = $clog2(REARM_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(N);
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [RW-1:0] REARM_LAST = RW'(REARM_CYCLES - 1);

  if (HALF_PERIOD < 3) begin : g_bad_half_period
    $error("timestamp_reader: HALF_PERIOD must be >= 3");
  end
  if (REARM_CYCLES < 1) begin : g_bad_rearm
    $error("timestamp_reader: REARM_CYCLES must be >= 1");
  end
  if (N < 2) begin : g_bad_frame
    $error("timestamp_reader: CHANNELS*WIDTH must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    PRESENT,
    REARM,
    WAIT_CLR
  } state_t;

  state_t          state;
  logic [PW-1:0]   phase;
  logic [CW-1:0]   bit_cnt;
  logic [RW-1:0]   rearm_cnt;
  logic [N-1:0]    sr;

  logic dr_meta, dr_sync;
  logic din_meta, din_sync;

  // Both chain signals cross from the timer board's domain; each gets its own 2-flop stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_meta  <= 1'b0;
      dr_sync  <= 1'b0;
      din_meta <= 1'b0;
      din_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value,
      // which is what builds a two-deep pipeline instead of a single wire.
      dr_meta  <= data_ready;
      dr_sync  <= dr_meta;
      din_meta <= data_in;
      din_sync <= din_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      bit_cnt      <= '0;
      rearm_cnt    <= '0;
      // NOTE: the shift register is plain flops, not a RAM, so clearing it on reset is free
      // and guarantees no partial frame survives an abort.
      sr           <= '0;
      timestamps   <= '0;
      data_clk     <= 1'b0;
      target_reset <= 1'b0;
      ts_valid     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dr_sync) begin
            bit_cnt <= '0;
            phase   <= '0;
            state   <= LOW;
          end
        end

        // Sample at the end of the low phase so the synchronized bit has settled.
        LOW: begin
          if (phase == PHASE_LAST) begin
            phase    <= '0;
            sr       <= {sr[N-2:0], din_sync};
            data_clk <= 1'b1;
            state    <= HIGH;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        HIGH: begin
          if (phase == PHASE_LAST) begin
            phase    <= '0;
            data_clk <= 1'b0;
            bit_cnt  <= bit_cnt + 1'b1;
            if ((bit_cnt + 1'b1) == BIT_LAST) begin
              timestamps <= sr;
              ts_valid   <= 1'b1;
              state      <= PRESENT;
            end else begin
              state <= LOW;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        PRESENT: begin
          if (ts_ready) begin
            ts_valid     <= 1'b0;
            target_reset <= 1'b1;
            rearm_cnt    <= '0;
            state        <= REARM;
          end
        end

        REARM: begin
          if (rearm_cnt == REARM_LAST) begin
            target_reset <= 1'b0;
            state        <= WAIT_CLR;
          end else begin
            rearm_cnt <= rearm_cnt + 1'b1;
          end
        end

        // Hold off until the chain drops data_ready so a stale frame is never re-read.
        WAIT_CLR: begin
          if (!dr_sync) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_timestamp_reader.sv
// Self-checking bench for timestamp_reader: a behavioural chain model feeds two builds
// (default and a small HALF_PERIOD=3 one); expected frames are the loaded channel words.
module tb_timestamp_reader;

  localparam int CH  = 4, W  = 32, HP  = 4, RC = 4, N  = CH * W;
  localparam int CH2 = 2, W2 = 8,  HP2 = 3,         N2 = CH2 * W2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          dr_a = 1'b0, ready_a = 1'b0;
  logic          din_a, dclk_a, trst_a, valid_a, busy_a;
  logic [N-1:0]  ts_a;
  logic          dr_b = 1'b0, ready_b = 1'b0;
  logic          din_b, dclk_b, trst_b, valid_b, busy_b;
  logic [N2-1:0] ts_b;

  // Chain model: the loaded frame leaves MSB-first, one bit per data_clk rising edge.
  logic [N-1:0]  frame_a = '0;
  logic [N2-1:0] frame_b = '0;
  int base_a = 0, base_b = 0;
  int edges_a = 0, edges_b = 0;
  int hi_a = 0, hi_b = 0, bad_hi_a = 0, bad_hi_b = 0;
  int errors = 0, checks = 0;

  function automatic logic chain_out(input logic [N-1:0] f, input int k, input int n);
    if (k < 0 || k >= n) return 1'b0;
    return f[n-1-k];
  endfunction

  assign din_a = chain_out(frame_a, edges_a - base_a, N);
  assign din_b = chain_out(N'(frame_b), edges_b - base_b, N2);

  timestamp_reader #(.CHANNELS(CH), .WIDTH(W), .HALF_PERIOD(HP), .REARM_CYCLES(RC)) dut_a (
    .clk(clk), .reset(reset), .data_ready(dr_a), .data_in(din_a), .data_clk(dclk_a),
    .target_reset(trst_a), .timestamps(ts_a), .ts_valid(valid_a), .ts_ready(ready_a),
    .busy(busy_a));

  timestamp_reader #(.CHANNELS(CH2), .WIDTH(W2), .HALF_PERIOD(HP2), .REARM_CYCLES(RC)) dut_b (
    .clk(clk), .reset(reset), .data_ready(dr_b), .data_in(din_b), .data_clk(dclk_b),
    .target_reset(trst_b), .timestamps(ts_b), .ts_valid(valid_b), .ts_ready(ready_b),
    .busy(busy_b));

  always @(posedge dclk_a) edges_a++;
  always @(posedge dclk_b) edges_b++;

  // High-phase width monitor: every completed high run must last exactly HALF_PERIOD cycles.
  always @(negedge clk) begin
    if (dclk_a) hi_a++;
    else begin
      if (hi_a != 0 && hi_a != HP) bad_hi_a++;
      hi_a = 0;
    end
    if (dclk_b) hi_b++;
    else begin
      if (hi_b != 0 && hi_b != HP2) bad_hi_b++;
      hi_b = 0;
    end
  end

  // Full read on the default build: start, shift, present, handshake, re-arm, wait-clear.
  task automatic read_frame_a(input logic [N-1:0] f, input int glitch_at, input int hold,
                              input bit from_reset);
    int n, lat, e0, b0;
    logic [N-1:0] snap;
    bit stable;
    frame_a = f;
    base_a  = edges_a;
    e0      = edges_a;
    b0      = bad_hi_a;
    if (from_reset) reset = 1'b0;
    else dr_a = 1'b1;

    n = 0;
    while (!busy_a && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL start_latency: got %0d cycles, want 3", n); end

    lat = 0;
    while (!valid_a && lat < N * 2 * HP + 20) begin
      @(negedge clk);
      lat++;
      if (lat == glitch_at) dr_a = 1'b0;
      if (glitch_at != 0 && lat == glitch_at + 2) dr_a = 1'b1;
    end
    checks++;
    if (lat != N * 2 * HP) begin
      errors++; $display("FAIL frame_latency: got %0d cycles, want %0d", lat, N * 2 * HP);
    end
    checks++;
    if (ts_a !== f) begin errors++; $display("FAIL frame_value: got %h want %h", ts_a, f); end

    stable = 1'b1;
    snap   = ts_a;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (valid_a !== 1'b1 || ts_a !== snap || trst_a !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL hold_stable: output changed while ts_ready low (hold=%0d)", hold); end

    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || trst_a !== 1'b1) begin
      errors++; $display("FAIL handshake: ts_valid=%b target_reset=%b, want 0 and 1", valid_a, trst_a);
    end

    n = 0;
    while (trst_a && n < RC + 10) begin n++; @(negedge clk); end
    checks++;
    if (n != RC) begin errors++; $display("FAIL rearm_width: got %0d cycles, want %0d", n, RC); end

    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (edges_a != e0 + N || busy_a !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL wait_clear: new activity with stale data_ready high"); end
    checks++;
    if (edges_a - e0 != N) begin errors++; $display("FAIL edge_count: got %0d, want %0d", edges_a - e0, N); end
    checks++;
    if (bad_hi_a != b0) begin errors++; $display("FAIL clk_high_width: %0d bad high phases", bad_hi_a - b0); end

    dr_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL return_idle: busy=%b want 0", busy_a); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dclk_a, trst_a, valid_a, busy_a} !== 4'b0 || ts_a !== '0) begin
      errors++; $display("FAIL reset_a: clk=%b trst=%b valid=%b busy=%b ts=%h, want all 0",
                         dclk_a, trst_a, valid_a, busy_a, ts_a);
    end
    checks++;
    if ({dclk_b, trst_b, valid_b, busy_b} !== 4'b0 || ts_b !== '0) begin
      errors++; $display("FAIL reset_b: clk=%b trst=%b valid=%b busy=%b ts=%h, want all 0",
                         dclk_b, trst_b, valid_b, busy_b, ts_b);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_frame();
    read_frame_a({32'h12345678, 32'hDEADBEEF, 32'h80000000, 32'h00000001}, 0, 50, 1'b0);
  endtask

  task automatic test_second_frame();
    read_frame_a({32'hCAFEF00D, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000000}, 0, 3, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    frame_a = {$urandom, $urandom, $urandom, $urandom};
    base_a  = edges_a;
    dr_a    = 1'b1;
    n = 0;
    while (edges_a - base_a < 40 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (edges_a - base_a != 40) begin errors++; $display("FAIL abort_point: got %0d edges, want 40", edges_a - base_a); end
    reset = 1'b1;
    #1;
    checks++;
    if (dclk_a !== 1'b0 || busy_a !== 1'b0 || ts_a !== '0 || valid_a !== 1'b0 || trst_a !== 1'b0) begin
      errors++; $display("FAIL reset_abort: clk=%b busy=%b valid=%b trst=%b ts=%h, want all 0",
                         dclk_a, busy_a, valid_a, trst_a, ts_a);
    end
    repeat (3) @(negedge clk);
    read_frame_a({$urandom, $urandom, $urandom, $urandom}, 0, 5, 1'b1);
  endtask

  task automatic test_glitch();
    read_frame_a({$urandom, $urandom, $urandom, $urandom}, 300, 2, 1'b0);
  endtask

  task automatic test_ready_early();
    ready_a = 1'b1;
    read_frame_a({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2; i++)
      read_frame_a({$urandom, $urandom, $urandom, $urandom}, 0, int'($urandom_range(0, 6)), 1'b0);
  endtask

  task automatic read_frame_b(input logic [N2-1:0] f);
    int n, lat, e0, b0;
    frame_b = f;
    base_b  = edges_b;
    e0      = edges_b;
    b0      = bad_hi_b;
    dr_b    = 1'b1;
    n = 0;
    while (!busy_b && n < 10) begin @(negedge clk); n++; end
    lat = 0;
    while (!valid_b && lat < N2 * 2 * HP2 + 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat != N2 * 2 * HP2) begin
      errors++; $display("FAIL small_latency: got %0d cycles, want %0d", lat, N2 * 2 * HP2);
    end
    checks++;
    if (ts_b !== f) begin errors++; $display("FAIL small_frame: got %h want %h", ts_b, f); end
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    n = 0;
    while (trst_b && n < RC + 10) begin n++; @(negedge clk); end
    checks++;
    if (n != RC) begin errors++; $display("FAIL small_rearm: got %0d cycles, want %0d", n, RC); end
    checks++;
    if (edges_b - e0 != N2 || bad_hi_b != b0) begin
      errors++; $display("FAIL small_clock: edges=%0d bad_high=%0d, want %0d and 0", edges_b - e0, bad_hi_b - b0, N2);
    end
    dr_b = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_small();
    read_frame_b({8'h3C, 8'hA5});
    read_frame_b(N2'($urandom));
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_second_frame();
    test_reset_mid_shift();
    test_glitch();
    test_ready_early();
    test_random();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timestamp_reader.md
# timestamp_reader

Host-side reader for the trigger-timer capture chain. Waits for the chain's `data_ready`, then generates the serial data clock and shifts in all CHANNELS×WIDTH captured timestamp bits. It presents them as one parallel word with a valid/ready handshake, and then pulses the chain's reset to re-arm it for the next event. It sits on the controller FPGA, directly across the wires from the timer board's `DATA_READY` / `DATA_CLK` / `DATA_OUT` / `RESET` pins.

## Interface
Parameters:
- `CHANNELS`, default 4: number of trigger timers in the chain.
- `WIDTH`, default 32: bits per timestamp.
- `HALF_PERIOD`, default 4: clk cycles per `data_clk` phase. Must be ≥3; elaborate-time error otherwise.
- `REARM_CYCLES`, default 4: clk cycles that `target_reset` is held high.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data_ready`  in  1  chain "all channels captured"; asynchronous to `clk`.
- `data_in`  in  1  serial output of the last timer in the chain; asynchronous to `clk`.
- `data_clk`  out  1  shift clock to the chain; idles low.
- `target_reset`  out  1  re-arm pulse to the chain's reset.
- `timestamps`  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `ts_valid`  out  1  `timestamps` holds a complete, unconsumed frame.
- `ts_ready`  in  1  consumer accepts the frame.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronization:
  - `data_ready` passes through its own 2-flop synchronizer.
  - `data_in` passes through its own 2-flop synchronizer.
  - All logic uses the synchronized versions.
- Bit ordering:
  - Shift register `sr` is CHANNELS*WIDTH bits, shifted left with the new bit entering at bit 0.
  - The first sampled bit is the MSB of channel CHANNELS-1, because the last timer in the chain is nearest `data_in`.
  - After N = CHANNELS*WIDTH samples, `sr` maps 1:1 onto `timestamps`.
- States:
  - IDLE: `data_clk`=0. On synced `data_ready`=1, clear the bit counter and phase counter, then go to LOW.
  - LOW: `data_clk`=0 for HALF_PERIOD cycles. On the last cycle, shift the synced `data_in` into `sr`, then go to HIGH.
  - HIGH: `data_clk`=1 for HALF_PERIOD cycles. On the last cycle, increment the bit counter.
    - If count = N, go to PRESENT.
    - Otherwise go to LOW.
    - The final (N-th) rising edge is issued and harmless.
  - PRESENT: `timestamps` ← `sr`, registered on entry. `ts_valid`=1 and stays high until `ts_ready`=1 is sampled, then go to REARM.
  - REARM: `target_reset`=1 for exactly REARM_CYCLES cycles, then go to WAIT_CLR.
  - WAIT_CLR: stay until synced `data_ready`=0, then go to IDLE. This prevents re-reading a stale frame.
- `timestamps` holds its last value in every state and is updated only on entry to PRESENT.
- The bit counter is $clog2(N+1) bits wide. It never wraps; its terminal value is N.
- Edge cases:
  - `data_ready` dropping during LOW/HIGH is ignored. The frame completes; the data is whatever the chain shifts out.
  - `ts_ready` high outside PRESENT has no effect.
  - `reset` asserted mid-shift aborts immediately. All outputs return to reset values and the partial frame is discarded. After release, a still-high `data_ready` starts a full new read from bit 0.

## Timing
- Reset values:
  - `data_clk`=0, `target_reset`=0, `ts_valid`=0, `busy`=0, `timestamps`=0.
  - `sr`, counters and synchronizers cleared; state IDLE.
- `data_ready` rising at the pins reaches IDLE→LOW after 2 sync cycles plus 1 cycle.
- Each bit takes 2×HALF_PERIOD clk cycles.
- `data_in` is sampled HALF_PERIOD-1 cycles after the previous falling edge. This covers the 2-cycle sync delay plus chain output settling.
- Frame latency, from the LOW entry to `ts_valid`=1, is N×2×HALF_PERIOD cycles. This is 1024 cycles at the defaults.
- Handshake:
  - Transfer occurs on the cycle where `ts_valid`=1 and `ts_ready`=1.
  - `ts_valid` goes low the next cycle.
  - `target_reset` rises on that same next cycle.
  - If `ts_ready` is held high, `ts_valid` is high for exactly 1 cycle.
- `busy` is combinational from state and is high from the LOW entry through the WAIT_CLR exit.

## Test plan
- Chain model loaded with ch0=0x00000001, ch1=0x80000000, ch2=0xDEADBEEF, ch3=0x12345678; raise `data_ready` -> exactly 128 `data_clk` rising edges, each high 4 cycles, and `timestamps`=0x12345678_DEADBEEF_80000000_00000001 with `ts_valid`=1.
- `ts_ready` held low for 50 cycles after `ts_valid` -> `ts_valid` and `timestamps` stable and no `target_reset`; then `ts_ready`=1 for 1 cycle -> `ts_valid` low next cycle and `target_reset` high for exactly 4 cycles.
- After re-arm, model keeps `data_ready`=1 for 20 cycles -> no new `data_clk` edges until `data_ready` falls and rises again; the second frame's values appear correctly.
- `reset` pulse after the 40th rising edge -> `data_clk`=0, `busy`=0 and `timestamps`=0 immediately; on release with `data_ready` still 1 -> fresh 128-bit read giving the correct frame.
- `data_ready` glitch low for 2 cycles mid-shift -> the frame still completes with 128 edges; output matches the chain contents.
- HALF_PERIOD=3, CHANNELS=2, WIDTH=8 build with ch0=0xA5, ch1=0x3C -> `timestamps`=0x3CA5 after 16 edges of 6-cycle period.
